png_score_counter: RTL
======================

Name: png_score_counter

Overview:
- Per-player score counter for the Pong recreation, downstream of the miss-detection logic and feeding the score display decoders and the game-over logic.
- Replaces the discrete decade-counter-plus-flip-flop score chain with one fully synchronous block.
- Counts points 0..WIN_SCORE in BCD (units digit plus one tens bit), flags game over, and emits a one-cycle score pulse for the sound logic.

Parameters:
- WIN_SCORE, 11, terminal score that ends the game; legal range 1..19; 15 is the alternate cabinet setting.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- _reset  input  1  synchronous active-low reset; highest priority.
- _clr  input  1  active-low game-start clear; synchronous.
- _miss  input  1  active-low miss strobe from the ball logic; already synchronous to clk; may stay low for many cycles.
- units  output  4  BCD units digit, 0..9.
- tens  output  1  tens digit, 0 or 1.
- stop_g  output  1  high while score equals WIN_SCORE (game over).
- score_pulse  output  1  one-cycle pulse on each accepted point.

Behaviour:
- Reset (_reset=0 at a clock edge):
  - units=0, tens=0, stop_g=0, score_pulse=0.
  - Edge-detect register miss_q=1.
  - Applies mid-count and mid-pulse; overrides all other inputs.
- Edge detect:
  - miss_q samples _miss every cycle.
  - A point is accepted when miss_q=1 and _miss=0 (falling edge).
  - A held-low _miss counts once; a one-cycle low counts once.
- Increment timing:
  - On an accepted point with stop_g=0, units/tens update at the same clock edge that detects the falling edge. Zero added latency: the new value is visible in the cycle after _miss first reads low.
  - score_pulse is registered and high for exactly that one cycle.
- BCD rules:
  - units 0..8 increments by 1.
  - units=9 wraps to 0 and sets tens=1.
  - tens never exceeds 1; with WIN_SCORE ≤ 19 a wrap from 19 is unreachable.
- stop_g:
  - Registered; equals (tens*10+units == WIN_SCORE).
  - Asserts in the same cycle the terminal value appears.
- Saturation: while stop_g=1, accepted points are ignored. Counters hold, score_pulse stays 0, and miss_q still tracks _miss.
- _clr=0 (with _reset=1):
  - units=0, tens=0, stop_g=0, score_pulse=0.
  - miss_q still samples _miss.
  - Takes priority over a simultaneous falling edge; that point is lost.
- _clr and the miss edge both inactive: all outputs hold.
- Illegal WIN_SCORE (0 or >19): elaboration error.

Optional Feature:
- Macro: PNG_SCORE_SEG_EN.
- When defined:
  - Adds outputs seg_u[6:0] and seg_t[6:0], active-high, bit order g..a.
  - Both are registered from the next-state digits, so they change on the same edge as units/tens.
  - seg_t is blanked (all 0) when tens=0 (leading-zero blanking); seg_t shows "1" (segments b,c) when tens=1.
  - Reset and _clr drive seg_u to the "0" pattern and seg_t to blank.
- When undefined: neither port exists and no segment logic is generated.

Decomposition:
- Package png_score_pkg holds:
  - The BCD digit typedef (4-bit).
  - The localparam 7-segment patterns for 0..9 and blank.
  - A function for the WIN_SCORE legality check.
- Sub-module png_bcd_digit: synchronous decade counter with inc enable, synchronous active-low clear, and carry-out at 9. The units digit instantiates it.
- The tens bit and stop logic stay in the top.

Test Plan:
- Reset: hold _reset=0 for 3 cycles with _miss toggling -> units=0, tens=0, stop_g=0, score_pulse=0 throughout and after release.
- Single point: _miss high, then low for 20 cycles -> units 0→1 exactly once, score_pulse high for one cycle, in the cycle after _miss first reads low.
- Digit wrap: 10 separate low strobes -> units reaches 9, then wraps to units=0, tens=1; score_pulse count=10.
- Game over (WIN_SCORE=11): 13 strobes -> stop_g=1 at units=1, tens=1; strobes 12–13 leave the score at 11 with no score_pulse.
- Clear priority: at score 7, assert _clr=0 in the same cycle as a _miss falling edge -> score 0, stop_g=0, score_pulse=0, no increment afterwards.
- WIN_SCORE=15, with PNG_SCORE_SEG_EN: 15 strobes -> stop_g=1, seg_t=7'b0000110, seg_u=7'b1101101; at score 9, seg_t=0 (blank).

Source files
------------

// File: rtl/png_score_pkg.sv
// Shared types, 7-segment patterns and the WIN_SCORE legality check for the
// Pong score counter. Segment vectors are active-high, bit order g..a.
package png_score_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // The tens digit is a single bit, so anything past 19 cannot be displayed.
  function automatic bit win_score_legal(input int w);
    return (w >= 1) && (w <= 19);
  endfunction

  function automatic logic [6:0] seg_of(input bcd_t d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/png_bcd_digit.sv
// Synchronous decade counter: increment enable, active-low synchronous clear,
// combinational carry when incrementing from 9. Exposes its next value too.
module png_bcd_digit
  import png_score_pkg::*;
(
  input  logic clk,
  input  logic _clr,
  input  logic inc,
  output bcd_t digit,
  output bcd_t digit_nxt,
  output logic carry
);

  assign carry = inc && (digit == 4'd9);

  always_comb begin
    digit_nxt = digit;
    if (!_clr)
      digit_nxt = '0;
    else if (inc)
      digit_nxt = carry ? 4'd0 : digit + 4'd1;
  end

  always_ff @(posedge clk)
    digit <= digit_nxt;

endmodule

// File: rtl/png_score_counter.sv
// Per-player Pong score counter: BCD units digit plus one tens bit, game-over
// flag and point pulse. Optional segment outputs when PNG_SCORE_SEG_EN is defined.
module png_score_counter
  import png_score_pkg::*;
#(
  parameter int WIN_SCORE = 11
) (
  input  logic       clk,
  input  logic       _reset,
  input  logic       _clr,
  input  logic       _miss,
  output logic [3:0] units,
  output logic       tens,
  output logic       stop_g,
  output logic       score_pulse
`ifdef PNG_SCORE_SEG_EN
  ,
  output logic [6:0] seg_u,
  output logic [6:0] seg_t
`endif
);

  if (!win_score_legal(WIN_SCORE)) begin : g_bad_win_score
    $error("png_score_counter: WIN_SCORE must be in 1..19");
  end

  localparam logic [4:0] WIN = 5'(WIN_SCORE);

  logic       miss_q;
  logic       clear_n;
  logic       inc;
  logic       carry;
  logic       tens_nxt;
  bcd_t       units_nxt;
  logic [4:0] score_nxt;

  assign clear_n = _reset & _clr;
  // Falling edge of _miss; points are dropped once the game is over.
  assign inc     = miss_q && !_miss && !stop_g;

  png_bcd_digit u_units (
    .clk       (clk),
    ._clr      (clear_n),
    .inc       (inc),
    .digit     (units),
    .digit_nxt (units_nxt),
    .carry     (carry)
  );

  always_comb begin
    tens_nxt = tens;
    if (!clear_n)
      tens_nxt = 1'b0;
    else if (carry)
      tens_nxt = 1'b1;
  end

  assign score_nxt = {1'b0, units_nxt} + (tens_nxt ? 5'd10 : 5'd0);

  // Reset parks miss_q high so a _miss already low at release counts as a point.
  always_ff @(posedge clk) begin
    if (!_reset)
      miss_q <= 1'b1;
    else
      miss_q <= _miss;
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      tens        <= 1'b0;
      stop_g      <= 1'b0;
      score_pulse <= 1'b0;
    end else begin
      tens        <= tens_nxt;
      stop_g      <= (score_nxt == WIN);
      score_pulse <= inc;
    end
  end

`ifdef PNG_SCORE_SEG_EN
  always_ff @(posedge clk) begin
    seg_u <= seg_of(units_nxt);
    seg_t <= tens_nxt ? SEG_1 : SEG_BLANK;
  end
`endif

endmodule
